// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One frame per low-to-high transmit request; o_txd is always a registered output.
module uart_tx #(
    parameter int DIVISOR   = 208,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_send,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_txd
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam logic [15:0] BIT_LOAD  = 16'(DIVISOR - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        armed_q, armed_d;
    logic        busy_q, busy_d;
    logic        txd_q, txd_d;

    logic        baud_done;
    logic [2:0]  bit_nxt;
    logic        par_bit;

    assign baud_done = (baud_q == 16'd0);
    assign bit_nxt   = bit_q + 3'd1;
    assign par_bit   = (PARITY == 2) ? ~^data_q : ^data_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        busy_d  = busy_q;
        txd_d   = txd_q;
        // armed re-arms whenever the host drops its request, so a held level
        // can never trigger a second frame
        armed_d = armed_q | ~i_send;

        case (state_q)
            IDLE: begin
                if (i_send && armed_q) begin
                    data_d  = i_data;
                    armed_d = 1'b0;
                    state_d = START;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                    baud_d  = BIT_LOAD;
                    bit_d   = 3'd0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    txd_d   = data_q[0];
                    baud_d  = BIT_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BIT_LOAD;
                    bit_d  = bit_nxt;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                        txd_d   = (PARITY != 0) ? par_bit : 1'b1;
                    end else begin
                        txd_d = data_q[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            PAR: begin
                if (baud_done) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    baud_d  = BIT_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d  = bit_nxt;
                        baud_d = BIT_LOAD;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            armed_q <= 1'b1;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
        end
    end

    assign o_busy = busy_q;
    assign o_txd  = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity / even / odd+2 stop) share stimulus and are
// compared cycle by cycle against a frame model built from bit lists.
module tb_uart_tx;

    localparam int DIV = 4;
    localparam int W   = 52;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_send = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       b0, b1, b2, t0, t1, t2;

    int  checks = 0;
    int  errors = 0;
    int  rn = 0;
    int  cfg_p [3] = '{0, 1, 2};
    int  cfg_s [3] = '{1, 1, 2};
    bit  rtxd  [3][256];
    bit  rbusy [3][256];
    bit  etxd  [3][256];
    bit  ebusy [3][256];

    always #5 clk = ~clk;

    uart_tx #(.DIVISOR(DIV), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset_n(reset_n), .i_send(i_send), .i_data(i_data), .o_busy(b0), .o_txd(t0));
    uart_tx #(.DIVISOR(DIV), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset_n(reset_n), .i_send(i_send), .i_data(i_data), .o_busy(b1), .o_txd(t1));
    uart_tx #(.DIVISOR(DIV), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .reset_n(reset_n), .i_send(i_send), .i_data(i_data), .o_busy(b2), .o_txd(t2));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // sample one cycle's outputs shortly after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rn < 256) begin
            rtxd[0][rn] = t0; rbusy[0][rn] = b0;
            rtxd[1][rn] = t1; rbusy[1][rn] = b1;
            rtxd[2][rn] = t2; rbusy[2][rn] = b2;
        end
        rn++;
    endtask

    task automatic exp_idle();
        for (int u = 0; u < 3; u++)
            for (int k = 0; k < 256; k++) begin
                etxd[u][k]  = 1'b1;
                ebusy[u][k] = 1'b0;
            end
    endtask

    // line levels of one frame, each held DIV cycles, starting at sample index 'start'
    task automatic exp_frame(input int u, input logic [7:0] d, input int start, output int len);
        bit lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(d[i]);
        if (cfg_p[u] == 1) lv.push_back(^d);
        if (cfg_p[u] == 2) lv.push_back(~^d);
        for (int i = 0; i < cfg_s[u]; i++) lv.push_back(1'b1);
        len = lv.size() * DIV;
        for (int k = 0; k < len; k++)
            if (start + k < 256) begin
                etxd[u][start + k]  = lv[k / DIV];
                ebusy[u][start + k] = 1'b1;
            end
    endtask

    function automatic int first_diff(input int u, input int n);
        for (int k = 0; k < n; k++)
            if (rtxd[u][k] !== etxd[u][k] || rbusy[u][k] !== ebusy[u][k]) return k;
        return -1;
    endfunction

    function automatic int busy_count(input int u, input int from, input int n);
        int c = 0;
        for (int k = from; k < n; k++) c += int'(rbusy[u][k]);
        return c;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        i_send  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_send  = 1'b1;
        i_data  = 8'hA5;
        tick();
        checks++;
        if ({t2, t1, t0} !== 3'b111) begin
            errors++;
            $display("FAIL reset_txd: got %b, expected 111", {t2, t1, t0});
        end
        checks++;
        if ({b2, b1, b0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_busy: got %b, expected 000", {b2, b1, b0});
        end
        i_send = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int len, bad;
        exp_idle();
        for (int u = 0; u < 3; u++) exp_frame(u, 8'h55, 0, len);
        i_data = 8'h55;
        i_send = 1'b1;
        rn = 0;
        tick();
        i_send = 1'b0;
        repeat (W - 1) begin
            i_data = 8'($urandom);
            tick();
        end
        for (int u = 0; u < 3; u++) begin
            bad = first_diff(u, W);
            checks++;
            if (bad !== -1) begin
                errors++;
                $display("FAIL basic_0x55 dut%0d cycle %0d: txd=%0b busy=%0b, expected txd=%0b busy=%0b",
                         u, bad, rtxd[u][bad], rbusy[u][bad], etxd[u][bad], ebusy[u][bad]);
            end
        end
        checks++;
        if (busy_count(0, 0, W) !== 40) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d cycles, expected 40", busy_count(0, 0, W));
        end
    endtask

    task automatic test_hold();
        int len, bad;
        exp_idle();
        for (int u = 0; u < 3; u++) exp_frame(u, 8'h41, 0, len);
        i_data = 8'h41;
        i_send = 1'b1;
        rn = 0;
        repeat (200) tick();
        i_send = 1'b0;
        for (int u = 0; u < 3; u++) begin
            bad = first_diff(u, 200);
            checks++;
            if (bad !== -1) begin
                errors++;
                $display("FAIL hold_one_frame dut%0d cycle %0d: txd=%0b busy=%0b, expected txd=%0b busy=%0b",
                         u, bad, rtxd[u][bad], rbusy[u][bad], etxd[u][bad], ebusy[u][bad]);
            end
        end
        checks++;
        if (busy_count(0, 40, 200) !== 0) begin
            errors++;
            $display("FAIL hold_busy_after_40: got %0d busy cycles, expected 0", busy_count(0, 40, 200));
        end
        tick();
    endtask

    task automatic test_parity();
        int len, bad;
        bit [3:0] s1, s2;
        exp_idle();
        for (int u = 0; u < 3; u++) exp_frame(u, 8'h07, 0, len);
        i_data = 8'h07;
        i_send = 1'b1;
        rn = 0;
        tick();
        i_send = 1'b0;
        repeat (W - 1) tick();
        for (int u = 1; u < 3; u++) begin
            bad = first_diff(u, W);
            checks++;
            if (bad !== -1) begin
                errors++;
                $display("FAIL parity_frame dut%0d cycle %0d: txd=%0b busy=%0b, expected txd=%0b busy=%0b",
                         u, bad, rtxd[u][bad], rbusy[u][bad], etxd[u][bad], ebusy[u][bad]);
            end
        end
        s1 = {rtxd[1][39], rtxd[1][38], rtxd[1][37], rtxd[1][36]};
        s2 = {rtxd[2][39], rtxd[2][38], rtxd[2][37], rtxd[2][36]};
        checks++;
        if (s1 !== 4'b1111) begin
            errors++;
            $display("FAIL parity_even_slot: got %b, expected 1111", s1);
        end
        checks++;
        if (s2 !== 4'b0000) begin
            errors++;
            $display("FAIL parity_odd_slot: got %b, expected 0000", s2);
        end
        checks++;
        if (busy_count(1, 0, W) !== 44) begin
            errors++;
            $display("FAIL parity_frame_len: got %0d cycles, expected 44", busy_count(1, 0, W));
        end
    endtask

    // random bytes, random request hold time, i_data scrambled after acceptance
    task automatic test_random();
        int len, bad, h;
        logic [7:0] d;
        for (int it = 0; it < 20; it++) begin
            d = 8'($urandom);
            h = $urandom_range(1, 3);
            exp_idle();
            for (int u = 0; u < 3; u++) exp_frame(u, d, 0, len);
            i_data = d;
            i_send = 1'b1;
            rn = 0;
            tick();
            for (int j = 1; j < W; j++) begin
                if (j >= h) i_send = 1'b0;
                i_data = 8'($urandom);
                tick();
            end
            i_send = 1'b0;
            for (int u = 0; u < 3; u++) begin
                bad = first_diff(u, W);
                checks++;
                if (bad !== -1) begin
                    errors++;
                    $display("FAIL random_0x%02h dut%0d cycle %0d: txd=%0b busy=%0b, expected txd=%0b busy=%0b",
                             d, u, bad, rtxd[u][bad], rbusy[u][bad], etxd[u][bad], ebusy[u][bad]);
                end
            end
        end
    endtask

    task automatic host_wait(input logic want, output bit expired);
        int w = 0;
        expired = 1'b0;
        while (b0 !== want && w < 100) begin
            tick();
            w++;
        end
        if (b0 !== want) expired = 1'b1;
    endtask

    task automatic test_back_to_back();
        int len1, len2, bad;
        bit e1, e2, e3, e4;
        do_reset();
        tick();
        exp_idle();
        exp_frame(0, 8'h12, 0, len1);
        exp_frame(0, 8'hA5, len1 + 1, len2);
        i_data = 8'h12;
        i_send = 1'b1;
        rn = 0;
        tick();
        host_wait(1'b1, e1);
        i_send = 1'b0;
        host_wait(1'b0, e2);
        i_data = 8'hA5;
        i_send = 1'b1;
        tick();
        host_wait(1'b1, e3);
        i_send = 1'b0;
        host_wait(1'b0, e4);
        tick();
        checks++;
        if ({e1, e2, e3, e4} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_handshake_timeout: got expired=%b, expected 0000", {e1, e2, e3, e4});
        end
        bad = first_diff(0, len1 + len2 + 2);
        checks++;
        if (bad !== -1) begin
            errors++;
            $display("FAIL b2b_frames cycle %0d: txd=%0b busy=%0b, expected txd=%0b busy=%0b",
                     bad, rtxd[0][bad], rbusy[0][bad], etxd[0][bad], ebusy[0][bad]);
        end
        checks++;
        if (rbusy[0][len1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%0b at cycle %0d, expected 0", rbusy[0][len1], len1);
        end
    endtask

    task automatic test_reset_mid();
        int len, bad;
        do_reset();
        tick();
        i_data = 8'hFF;
        i_send = 1'b1;
        rn = 0;
        tick();
        i_send = 1'b0;
        repeat (14) tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({t2, t1, t0} !== 3'b111) begin
            errors++;
            $display("FAIL midreset_txd: got %b, expected 111", {t2, t1, t0});
        end
        checks++;
        if ({b2, b1, b0} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_busy: got %b, expected 000", {b2, b1, b0});
        end
        exp_idle();
        for (int u = 0; u < 3; u++) exp_frame(u, 8'h00, 0, len);
        reset_n = 1'b1;
        i_send  = 1'b1;
        i_data  = 8'h00;
        rn = 0;
        tick();
        i_send = 1'b0;
        repeat (W - 1) tick();
        for (int u = 0; u < 3; u++) begin
            bad = first_diff(u, W);
            checks++;
            if (bad !== -1) begin
                errors++;
                $display("FAIL midreset_new_frame dut%0d cycle %0d: txd=%0b busy=%0b, expected txd=%0b busy=%0b",
                         u, bad, rtxd[u][bad], rbusy[u][bad], etxd[u][bad], ebusy[u][bad]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_parity();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
